// File: rtl/dbg_core_agent.sv
// Core-side debug agent: halt/run/step control of the retire stage plus a buffered trace stream.
// Optional execute breakpoints are compiled in with `define DBG_AGENT_BP_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | core runs freely; halt request or breakpoint starts a halt
// ST_HALTING | retire stalled, waiting for the pipeline to drain
// ST_HALTED  | debug halt; halt_ack asserted, waits for step/run
// ST_STEP    | retire released until exactly one instruction retires
module dbg_core_agent #(
  parameter int TRACE_W          = 128,
  parameter int TRACE_FIFO_DEPTH = 4,
  parameter int BP_COUNT         = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               halt_req,
  input  logic               run_req,
  input  logic               step_req,
  input  logic               bp_valid,
  input  logic               bp_write,
  input  logic [7:0]         bp_index,
  input  logic [31:0]        bp_addr,
  input  logic [1:0]         bp_kind,
  input  logic               bp_enable,
  output logic               halt_ack,
  output logic               step_ack,
  output logic               trace_valid,
  output logic [TRACE_W-1:0] trace_data,
  input  logic               trace_ready,
  input  logic               core_retire_valid,
  input  logic [31:0]        core_retire_pc,
  input  logic [31:0]        core_retire_insn,
  input  logic               core_quiesced,
  output logic               core_stall,
  output logic               core_halted,
  output logic [15:0]        trace_drop_count
);

  typedef enum logic [1:0] {ST_RUN, ST_HALTING, ST_HALTED, ST_STEP} state_t;

  localparam int AW = (TRACE_FIFO_DEPTH > 1) ? $clog2(TRACE_FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(TRACE_FIFO_DEPTH);

  state_t state, state_d;
  logic   step_pend, step_pend_d, step_ack_d;
  logic   bp_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      step_pend <= 1'b0;
      step_ack  <= 1'b0;
    end else begin
      state     <= state_d;
      step_pend <= step_pend_d;
      step_ack  <= step_ack_d;
    end
  end

  always_comb begin
    state_d     = state;
    step_pend_d = step_pend;
    step_ack_d  = step_ack;
    case (state)
      ST_RUN: begin
        if (halt_req || (core_retire_valid && bp_hit)) state_d = ST_HALTING;
      end
      ST_HALTING: begin
        if (core_quiesced) begin
          state_d = ST_HALTED;
          if (step_pend) begin
            step_ack_d  = 1'b1;
            step_pend_d = 1'b0;
          end
        end
      end
      ST_HALTED: begin
        if (step_req) begin
          state_d    = ST_STEP;
          step_ack_d = 1'b0;
        end else if (run_req && !halt_req) begin
          state_d    = ST_RUN;
          step_ack_d = 1'b0;
        end
      end
      ST_STEP: begin
        if (core_retire_valid) begin
          state_d     = ST_HALTING;
          step_pend_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign core_stall  = (state == ST_HALTING) || (state == ST_HALTED);
  assign core_halted = (state == ST_HALTED);
  assign halt_ack    = core_halted;

`ifdef DBG_AGENT_BP_EN
  localparam int BP_IW = (BP_COUNT > 1) ? $clog2(BP_COUNT) : 1;
  localparam logic [8:0] BP_LIM = 9'(BP_COUNT);

  logic [31:0] bp_addr_q [BP_COUNT];
  logic [1:0]  bp_kind_q [BP_COUNT];
  logic        bp_en_q   [BP_COUNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BP_COUNT; i++) begin
        bp_addr_q[i] <= 32'd0;
        bp_kind_q[i] <= 2'd0;
        bp_en_q[i]   <= 1'b0;
      end
    end else if (bp_valid && bp_write && ({1'b0, bp_index} < BP_LIM)) begin
      bp_addr_q[bp_index[BP_IW-1:0]] <= bp_addr;
      bp_kind_q[bp_index[BP_IW-1:0]] <= bp_kind;
      bp_en_q[bp_index[BP_IW-1:0]]   <= bp_enable;
    end
  end

  // only execute-kind (0) entries can match a retiring pc
  always_comb begin
    bp_hit = 1'b0;
    for (int i = 0; i < BP_COUNT; i++) begin
      if (bp_en_q[i] && (bp_kind_q[i] == 2'd0) && (bp_addr_q[i] == core_retire_pc)) bp_hit = 1'b1;
    end
  end
`else
  logic unused_bp;
  assign unused_bp = ^{bp_valid, bp_write, bp_index, bp_addr, bp_kind, bp_enable, BP_COUNT[0]};
  assign bp_hit    = 1'b0;
`endif

  logic [TRACE_W-1:0] fifo_mem [TRACE_FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        fifo_cnt;
  logic [31:0]        cyc_stamp;
  logic               ovf_pend;
  logic               fifo_full, pop, push_ok, drop;
  logic [TRACE_W-1:0] rec;

  assign fifo_full   = (fifo_cnt == DEPTH_C);
  assign trace_valid = (fifo_cnt != '0);
  assign trace_data  = fifo_mem[rd_ptr];
  assign pop         = trace_valid && trace_ready;
  assign push_ok     = core_retire_valid && (!fifo_full || pop);
  assign drop        = core_retire_valid && !push_ok;

  always_comb begin
    rec        = '0;
    rec[31:0]  = core_retire_pc;
    rec[63:32] = core_retire_insn;
    rec[95:64] = cyc_stamp;
    rec[96]    = (state == ST_STEP);
    rec[97]    = bp_hit && (state == ST_RUN);
    rec[98]    = ovf_pend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TRACE_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_cnt         <= '0;
      cyc_stamp        <= 32'd0;
      ovf_pend         <= 1'b0;
      trace_drop_count <= 16'd0;
    end else begin
      cyc_stamp <= cyc_stamp + 32'd1;
      if (push_ok) begin
        fifo_mem[wr_ptr] <= rec;
        wr_ptr           <= wr_ptr + 1'b1;
        ovf_pend         <= 1'b0;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (drop) begin
        ovf_pend <= 1'b1;
        if (trace_drop_count != 16'hFFFF) trace_drop_count <= trace_drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dbg_core_agent.sv
// Bench for dbg_core_agent: directed halt/step/overflow/reset scenarios plus random trace traffic
// against a queue-based model of the trace stream.
module tb_dbg_core_agent;
  localparam int TW = 128;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          halt_req = 1'b0, run_req = 1'b0, step_req = 1'b0;
  logic          bp_valid = 1'b0, bp_write = 1'b0, bp_enable = 1'b0;
  logic [7:0]    bp_index = 8'd0;
  logic [31:0]   bp_addr = 32'd0;
  logic [1:0]    bp_kind = 2'd0;
  logic          halt_ack, step_ack, trace_valid;
  logic [TW-1:0] trace_data;
  logic          trace_ready = 1'b0;
  logic          core_retire_valid = 1'b0;
  logic [31:0]   core_retire_pc = 32'd0, core_retire_insn = 32'd0;
  logic          core_quiesced = 1'b0;
  logic          core_stall, core_halted;
  logic [15:0]   trace_drop_count;

  dbg_core_agent #(.TRACE_W(TW), .TRACE_FIFO_DEPTH(DEPTH), .BP_COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .halt_req(halt_req), .run_req(run_req), .step_req(step_req),
    .bp_valid(bp_valid), .bp_write(bp_write), .bp_index(bp_index),
    .bp_addr(bp_addr), .bp_kind(bp_kind), .bp_enable(bp_enable),
    .halt_ack(halt_ack), .step_ack(step_ack),
    .trace_valid(trace_valid), .trace_data(trace_data), .trace_ready(trace_ready),
    .core_retire_valid(core_retire_valid), .core_retire_pc(core_retire_pc),
    .core_retire_insn(core_retire_insn), .core_quiesced(core_quiesced),
    .core_stall(core_stall), .core_halted(core_halted),
    .trace_drop_count(trace_drop_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // trace stream model: records waiting for delivery, drop count, pending overflow, cycle stamp
  logic [TW-1:0] mq[$];
  int            m_drops = 0;
  bit            m_ovf = 1'b0;
  int unsigned   m_cyc = 0;
  bit            exp_step = 1'b0, exp_bp = 1'b0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] mk_rec(input logic [31:0] pc, input logic [31:0] insn,
                                           input logic [31:0] stamp, input bit s, input bit b, input bit o);
    logic [TW-1:0] r;
    r = '0;
    r[31:0]  = pc;
    r[63:32] = insn;
    r[95:64] = stamp;
    r[96]    = s;
    r[97]    = b;
    r[98]    = o;
    return r;
  endfunction

  // one clock: check the stream outputs, cross the edge, then advance the model
  task automatic cycle();
    bit            pop;
    int            sz;
    logic [TW-1:0] r;
    check_val("trace_valid", trace_valid, mq.size() != 0);
    if (mq.size() != 0) check_val("trace_data", trace_data, mq[0]);
    check_val("drop_count", trace_drop_count, m_drops);
    sz  = mq.size();
    pop = (sz != 0) && trace_ready;
    r   = mk_rec(core_retire_pc, core_retire_insn, m_cyc, exp_step, exp_bp, m_ovf);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (core_retire_valid) begin
      if (sz < DEPTH || pop) begin
        mq.push_back(r);
        m_ovf = 1'b0;
      end else begin
        if (m_drops < 65535) m_drops++;
        m_ovf = 1'b1;
      end
    end
    m_cyc++;
    @(negedge clk);
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] insn);
    core_retire_valid = 1'b1;
    core_retire_pc    = pc;
    core_retire_insn  = insn;
    cycle();
    core_retire_valid = 1'b0;
  endtask

  task automatic bp_wr(input logic [7:0] idx, input logic [31:0] addr, input logic [1:0] kind, input logic en);
    bp_valid = 1'b1; bp_write = 1'b1;
    bp_index = idx; bp_addr = addr; bp_kind = kind; bp_enable = en;
    cycle();
    bp_valid = 1'b0; bp_write = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_stall"}, core_stall, 1'b0);
    check_val({tag, "_halted"}, core_halted, 1'b0);
    check_val({tag, "_halt_ack"}, halt_ack, 1'b0);
    check_val({tag, "_step_ack"}, step_ack, 1'b0);
    check_val({tag, "_trace_valid"}, trace_valid, 1'b0);
    check_val({tag, "_trace_data"}, trace_data, '0);
    check_val({tag, "_drops"}, trace_drop_count, 16'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_drops = 0;
    m_ovf   = 1'b0;
    m_cyc   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    model_reset();
    trace_ready = 1'b1;

    // halt/resume; halt beats run, and the retire in the request cycle is traced
    halt_req = 1'b1; run_req = 1'b1;
    retire(32'h40, 32'h33);
    halt_req = 1'b0; run_req = 1'b0;
    check_val("halting_stall", core_stall, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_val("halting_ack", halt_ack, 1'b0);
      check_val("halting_stall_hold", core_stall, 1'b1);
    end
    core_quiesced = 1'b1;
    cycle();
    check_val("halted_ack", halt_ack, 1'b1);
    check_val("halted_flag", core_halted, 1'b1);
    run_req = 1'b1; halt_req = 1'b1;
    cycle();
    check_val("run_blocked_by_halt", core_halted, 1'b1);
    halt_req = 1'b0;
    cycle();
    run_req = 1'b0;
    check_val("resume_ack", halt_ack, 1'b0);
    check_val("resume_stall", core_stall, 1'b0);

    // step_req in RUN has no effect
    step_req = 1'b1;
    retire(32'h80, 32'h6f);
    step_req = 1'b0;
    check_val("step_in_run_stall", core_stall, 1'b0);
    check_val("step_in_run_ack", step_ack, 1'b0);

    // single step, twice
    halt_req = 1'b1;
    cycle();
    halt_req = 1'b0;
    cycle();
    check_val("pre_step_halted", core_halted, 1'b1);
    step_req = 1'b1;
    cycle();
    step_req = 1'b0;
    check_val("step_stall_released", core_stall, 1'b0);
    cycle();
    check_val("step_wait_stall", core_stall, 1'b0);
    exp_step = 1'b1;
    retire(32'h100, 32'h13);
    exp_step = 1'b0;
    check_val("step_restall", core_stall, 1'b1);
    check_val("step_ack_early", step_ack, 1'b0);
    cycle();
    check_val("step_halted", core_halted, 1'b1);
    check_val("step_ack_set", step_ack, 1'b1);
    step_req = 1'b1;
    cycle();
    step_req = 1'b0;
    check_val("step2_ack_clear", step_ack, 1'b0);
    exp_step = 1'b1;
    retire(32'h104, 32'h93);
    exp_step = 1'b0;
    cycle();
    check_val("step2_ack_set", step_ack, 1'b1);
    run_req = 1'b1;
    cycle();
    run_req = 1'b0;
    check_val("run_after_step_stall", core_stall, 1'b0);
    check_val("run_clears_step_ack", step_ack, 1'b0);
    core_quiesced = 1'b0;

    // backpressure, overflow, then full with simultaneous pop and push
    repeat (2) cycle();
    trace_ready = 1'b0;
    for (int i = 0; i < 6; i++) retire(32'h1000 + 32'(4 * i), 32'(i));
    check_val("ovf_drops", trace_drop_count, 16'd2);
    check_val("ovf_held_valid", trace_valid, 1'b1);
    trace_ready = 1'b1;
    retire(32'h2000, 32'h77);
    check_val("full_pop_push_drops", trace_drop_count, 16'd2);
    repeat (6) cycle();
    check_val("ovf_drained", trace_valid, 1'b0);

    // random traffic in RUN
    for (int i = 0; i < 400; i++) begin
      core_retire_valid = 1'($urandom_range(0, 1));
      core_retire_pc    = $urandom() & 32'h0000_FFFC;
      core_retire_insn  = $urandom();
      trace_ready       = 1'($urandom_range(0, 1));
      cycle();
    end
    core_retire_valid = 1'b0;
    trace_ready = 1'b1;
    repeat (6) cycle();

    // asynchronous reset while halting with three records buffered
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) retire(32'h3000 + 32'(4 * i), 32'h13);
    halt_req = 1'b1;
    cycle();
    halt_req = 1'b0;
    check_val("mid_halting_stall", core_stall, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle();
    check_val("post_reset_stall", core_stall, 1'b0);
    trace_ready = 1'b1;
    retire(32'h500, 32'h1234);
    cycle();

    // breakpoints
    bp_wr(8'd1, 32'h200, 2'd0, 1'b1);
    bp_wr(8'd7, 32'h300, 2'd0, 1'b1);
`ifdef DBG_AGENT_BP_EN
    exp_bp = 1'b1;
    retire(32'h200, 32'h1);
    exp_bp = 1'b0;
    check_val("bp_halting", core_stall, 1'b1);
    check_val("bp_not_yet_halted", core_halted, 1'b0);
    core_quiesced = 1'b1;
    cycle();
    check_val("bp_halted", core_halted, 1'b1);
    core_quiesced = 1'b0;
    run_req = 1'b1;
    cycle();
    run_req = 1'b0;
    check_val("bp_resume", core_stall, 1'b0);
    retire(32'h300, 32'h2);
    check_val("bp_index_oob_ignored", core_stall, 1'b0);
    bp_wr(8'd1, 32'h200, 2'd1, 1'b1);
    retire(32'h200, 32'h3);
    check_val("bp_kind1_no_halt", core_stall, 1'b0);
`else
    retire(32'h200, 32'h1);
    check_val("bp_disabled_no_halt", core_stall, 1'b0);
`endif
    repeat (6) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dbg_core_agent.md
Name: dbg_core_agent

Overview:
- Core-side endpoint of the dbg_if debug protocol; the hub drives the other end.
- Consumes halt_req/run_req/step_req and produces halt_ack/step_ack.
- Stalls and releases the core retire stage.
- Produces trace records on the dbg_if trace stream through a small buffer.
- One instance per core, between the core pipeline and the debug hub.

Parameters:
TRACE_W, 128, trace record width; must be >= 99
TRACE_FIFO_DEPTH, 4, trace buffer entries; power of two, >= 2
BP_COUNT, 4, breakpoint entries (used only with DBG_AGENT_BP_EN)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
dbg  dbg_if.core  -  halt_req/run_req/step_req/bp_* in; halt_ack/step_ack/trace_valid/trace_data out; trace_ready in
core_retire_valid  input  1  one instruction retires this cycle
core_retire_pc  input  32  PC of retiring instruction
core_retire_insn  input  32  encoding of retiring instruction
core_quiesced  input  1  pipeline drained, no retire in flight
core_stall  output  1  blocks retirement in the same cycle
core_halted  output  1  core is in debug halt
trace_drop_count  output  16  saturating count of dropped trace records

Behaviour:
- Single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: state RUN; core_stall=0; core_halted=0; halt_ack=0; step_ack=0; trace_valid=0; trace_data=0; trace_drop_count=0; cycle stamp=0; FIFO empty.
- State machine: RUN, HALTING, HALTED, STEP.
  - core_stall = 1 in HALTING and HALTED; 0 in RUN and STEP. Decoded from registered state only.
  - halt_ack = core_halted = 1 only in HALTED.
- RUN:
  - halt_req=1 -> HALTING. halt_req beats run_req when both are set.
  - A retire in the cycle halt_req is first seen still completes and is traced.
- HALTING: core_quiesced=1 -> HALTED. halt_req dropping here does not abort the halt.
- HALTED:
  - step_req=1 (one-cycle pulse) -> STEP, and clear step_ack.
  - Otherwise run_req=1 and halt_req=0 -> RUN, and clear step_ack.
  - step_req has priority over run_req.
- STEP:
  - core_stall=0 until the first retire.
  - That retire is traced with the step flag set; next state HALTING with a step-pending mark.
  - Arriving in HALTED with the mark set sets step_ack=1 (sticky) and clears the mark.
  - Exactly one instruction retires per step.
- step_req outside HALTED is ignored.
- Cycle stamp: 32-bit free-running counter; increments every cycle; wraps 0xFFFFFFFF -> 0.
- Trace record, LSB first:
  - [31:0] pc; [63:32] insn; [95:64] cycle stamp at retire.
  - [96] step flag; [97] bp-hit flag.
  - [98] overflow flag: at least one record dropped since the previous enqueued record.
  - Remaining bits 0.
- Trace enqueue happens on any core_retire_valid cycle.
- Trace FIFO:
  - trace_valid = FIFO not empty; trace_data = head record, registered.
  - Pop on trace_valid && trace_ready.
  - Push is accepted if not full, or if a pop occurs in the same cycle while full.
  - Record order is preserved.
- Drop handling:
  - A push that is not accepted increments trace_drop_count, saturating at 0xFFFF.
  - The pending-overflow flag is set and is cleared by the next accepted push, which carries [98]=1.
- trace_data must be held stable while trace_valid=1 and trace_ready=0.

Optional Feature:
DBG_AGENT_BP_EN
- Defined:
  - BP_COUNT entries of {addr[31:0], enable, kind}, reset to 0.
  - bp_valid && bp_write writes entry bp_index from bp_addr/bp_kind/bp_enable.
  - bp_index >= BP_COUNT is ignored.
  - Only kind 0 (execute) matches.
  - In RUN, a retire whose pc equals an enabled kind-0 entry is traced with [97]=1 and moves to HALTING.
- Undefined: bp_* inputs are ignored, no breakpoint storage, [97] is always 0.

Test Plan:
- Halt/resume: in RUN pulse halt_req=1; hold core_quiesced=0 for 3 cycles, then 1 -> core_stall high 1 cycle after halt_req; halt_ack=1 exactly 1 cycle after quiesced; then halt_req=0, run_req=1 -> RUN, halt_ack=0, core_stall=0.
- Single step: from HALTED pulse step_req; core retires pc=0x100 insn=0x13 -> exactly one record: pc=0x100, [96]=1; core_stall=1 the following cycle; step_ack=1 after return to HALTED; second step_req clears step_ack then sets it again.
- Backpressure/overflow: DEPTH=4, trace_ready=0, 6 back-to-back retires -> 4 records held, trace_drop_count=2; raise trace_ready plus one more retire -> records in order, the 5th delivered carries [98]=1, drop count stays 2.
- Full + simultaneous pop/push: FIFO full, trace_ready=1 and retire same cycle -> push accepted, no drop.
- Reset mid-operation: assert rst_n low during HALTING with FIFO holding 3 records -> all outputs return to reset values asynchronously; trace_valid=0 and state RUN after release.
- With DBG_AGENT_BP_EN: write entry 1 addr=0x200 enable=1 kind=0; retire pc=0x200 in RUN -> record with [97]=1, HALTING, then HALTED on quiesced; same entry with kind=1 -> no halt.
